// File: rtl/data_mem_responder_pkg.sv
// rv32i_mem_pkg: access size codes, MMIO offsets and timer control bits
package rv32i_mem_pkg;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [7:0] MMIO_GPIO_OUT = 8'h00;
  localparam logic [7:0] MMIO_GPIO_IN = 8'h04;
  localparam logic [7:0] MMIO_TIMER_CNT = 8'h08;
  localparam logic [7:0] MMIO_TIMER_CMP = 8'h0C;
  localparam logic [7:0] MMIO_TIMER_CTRL = 8'h10;
  localparam int CTRL_EN = 0;
  localparam int CTRL_PEND = 1;
endpackage

// File: rtl/data_mem_responder_timer.sv
// mmio_timer: free-running compare timer with sticky pending flag
module mmio_timer
  import rv32i_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        en,
  output logic        pend
);
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic en_q, en_d, pend_q, pend_d;
  always_comb begin
    cnt_d = cnt_we ? wdata : cnt_q + {31'b0, en_q};
    cmp_d = cmp_we ? wdata : cmp_q;
    en_d = ctrl_we ? wdata[CTRL_EN] : en_q;
    pend_d = (en_q && cnt_q == cmp_q) || (pend_q && !(ctrl_we && wdata[CTRL_PEND]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      cmp_q <= '1;
      en_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      en_q <= en_d;
      pend_q <= pend_d;
    end
  end
  assign cnt = cnt_q;
  assign cmp = cmp_q;
  assign en = en_q;
  assign pend = pend_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressable RAM plus GPIO/timer MMIO for the RV32I data bus
module data_mem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          GPIO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_wr_en,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       dAddr,
  input  logic [31:0]       dWdata,
  output logic [31:0]       dRdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              misalign_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d, gpio_in_q, gpio_in_d;
  logic err_q, err_d;
  logic is_b, is_h, is_w, in_ram, in_mmio, mis, we, ram_we, mmio_we;
  logic [3:0] be;
  logic [31:0] wd, word, ld, mmio_rd, cnt, cmp;
  logic [7:0] byte_sel, off;
  logic [15:0] half_sel;
  logic [AW-1:0] idx;
  logic en, pend;
  always_comb begin
    is_b = d_funct3[1:0] == 2'b00;
    is_h = d_funct3[1:0] == 2'b01;
    is_w = !is_b && !is_h;
    in_ram = dAddr[31:AW+2] == '0;
    in_mmio = dAddr[31:8] == MMIO_BASE[31:8];
    off = dAddr[7:0];
    idx = dAddr[AW+1:2];
    mis = in_ram ? ((is_h && dAddr[0]) || (is_w && dAddr[1:0] != 2'b00))
                 : in_mmio && (!is_w || dAddr[1:0] != 2'b00);
    we = d_wr_en && !mis && !reset;
    ram_we = we && in_ram;
    mmio_we = we && in_mmio;
    be = is_b ? 4'b0001 << dAddr[1:0] : is_h ? (dAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = is_b ? {4{dWdata[7:0]}} : is_h ? {2{dWdata[15:0]}} : dWdata;
    word = mem[idx];
    byte_sel = word[{dAddr[1:0], 3'b000} +: 8];
    half_sel = dAddr[1] ? word[31:16] : word[15:0];
    ld = is_b ? {{24{!d_funct3[2] && byte_sel[7]}}, byte_sel}
       : is_h ? {{16{!d_funct3[2] && half_sel[15]}}, half_sel} : word;
    mmio_rd = off == MMIO_GPIO_OUT ? 32'(gpio_out_q)
            : off == MMIO_GPIO_IN ? 32'(gpio_in_q)
            : off == MMIO_TIMER_CNT ? cnt
            : off == MMIO_TIMER_CMP ? cmp
            : off == MMIO_TIMER_CTRL ? {30'b0, pend, en} : '0;
    dRdata = mis ? '0 : in_ram ? ld : in_mmio ? mmio_rd : '0;
    gpio_out_d = (mmio_we && off == MMIO_GPIO_OUT) ? dWdata[GPIO_W-1:0] : gpio_out_q;
    gpio_in_d = gpio_in;
    err_d = err_q || (d_wr_en && mis);
  end
  always_ff @(posedge clk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q <= '0;
      gpio_in_q <= '0;
      err_q <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_in_q <= gpio_in_d;
      err_q <= err_d;
    end
  end
  mmio_timer u_timer (
    .clk(clk),
    .reset(reset),
    .cnt_we(mmio_we && off == MMIO_TIMER_CNT),
    .cmp_we(mmio_we && off == MMIO_TIMER_CMP),
    .ctrl_we(mmio_we && off == MMIO_TIMER_CTRL),
    .wdata(dWdata),
    .cnt(cnt),
    .cmp(cmp),
    .en(en),
    .pend(pend)
  );
  assign gpio_out = gpio_out_q;
  assign timer_irq = pend;
  assign misalign_err = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus with a queued scoreboard and negedge monitor
module tb_data_mem_responder;
  import rv32i_mem_pkg::*;
  localparam logic [31:0] MB = 32'h8000_0000;
  localparam int S_RD = 0, S_GPIO = 1, S_IRQ = 2, S_ERR = 3;
  logic clk = 1'b0, reset = 1'b1, d_wr_en = 1'b0;
  logic [2:0] d_funct3 = F3_W;
  logic [31:0] dAddr = '0, dWdata = '0, dRdata;
  logic [7:0] gpio_in = 8'h3C, gpio_out;
  logic timer_irq, misalign_err;
  int checks = 0, errors = 0;
  logic mon_v = 1'b0;
  int q_sel[$];
  logic [31:0] q_exp[$];
  string q_name[$];
  int m_sel;
  logic [31:0] m_act, m_exp;
  string m_name;
  data_mem_responder dut (
    .clk(clk),
    .reset(reset),
    .d_wr_en(d_wr_en),
    .d_funct3(d_funct3),
    .dAddr(dAddr),
    .dWdata(dWdata),
    .dRdata(dRdata),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .timer_irq(timer_irq),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mon_v) begin
      checks++;
      if (q_sel.size() == 0) begin
        errors++;
        $display("FAIL monitor: output presented with no expectation queued");
      end else begin
        m_sel = q_sel.pop_front();
        m_exp = q_exp.pop_front();
        m_name = q_name.pop_front();
        m_act = m_sel == S_RD ? dRdata : m_sel == S_GPIO ? {24'b0, gpio_out}
              : m_sel == S_IRQ ? {31'b0, timer_irq} : {31'b0, misalign_err};
        if (m_act !== m_exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
        end
      end
    end
  end
  task automatic cyc(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input int sel, input logic [31:0] exp, input string name);
    d_wr_en = wr;
    d_funct3 = f3;
    dAddr = a;
    dWdata = d;
    mon_v = sel >= 0;
    if (sel >= 0) begin
      q_sel.push_back(sel);
      q_exp.push_back(exp);
      q_name.push_back(name);
    end
    @(posedge clk);
    #1;
    d_wr_en = 1'b0;
    mon_v = 1'b0;
  endtask
  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, f3, a, d, -1, '0, "");
  endtask
  task automatic stc(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input int sel, input logic [31:0] exp, input string name);
    cyc(1'b1, f3, a, d, sel, exp, name);
  endtask
  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp, input string name);
    cyc(1'b0, f3, a, '0, S_RD, exp, name);
  endtask
  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    cyc(1'b0, F3_W, '0, '0, sel, exp, name);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ld(F3_W, MB + 32'h04, 32'h0, "gpio_in_rst");
    chk(S_GPIO, 32'h0, "gpio_out_rst");
    chk(S_IRQ, 32'h0, "irq_rst");
    chk(S_ERR, 32'h0, "err_rst");
    ld(F3_W, MB + 32'h08, 32'h0, "cnt_rst");
    ld(F3_W, MB + 32'h0C, 32'hFFFF_FFFF, "cmp_rst");
    ld(F3_W, MB + 32'h10, 32'h0, "ctrl_rst");
    ld(F3_W, MB + 32'h04, 32'h3C, "gpio_in_3c");
    gpio_in = 8'h5A;
    ld(F3_W, MB + 32'h04, 32'h3C, "gpio_in_latency");
    ld(F3_W, MB + 32'h04, 32'h5A, "gpio_in_5a");
    stc(F3_W, MB, 32'hA5, S_GPIO, 32'h0, "gpio_out_pre");
    chk(S_GPIO, 32'hA5, "gpio_out_a5");
    ld(F3_W, MB, 32'hA5, "gpio_out_rd");
    st(F3_W, 32'h10, 32'h8765_4321);
    ld(F3_B, 32'h10, 32'h0000_0021, "lb_10");
    ld(F3_BU, 32'h10, 32'h21, "lbu_10");
    ld(F3_H, 32'h10, 32'h4321, "lh_10");
    ld(F3_HU, 32'h10, 32'h4321, "lhu_10");
    ld(F3_W, 32'h10, 32'h8765_4321, "lw_10");
    ld(F3_B, 32'h11, 32'h43, "lb_11");
    ld(F3_H, 32'h12, 32'hFFFF_8765, "lh_12");
    ld(F3_HU, 32'h12, 32'h8765, "lhu_12");
    ld(F3_B, 32'h13, 32'hFFFF_FF87, "lb_13");
    ld(F3_BU, 32'h13, 32'h87, "lbu_13");
    st(F3_W, 32'h14, 32'h1111_1111);
    stc(F3_W, 32'h14, 32'h2222_2222, S_RD, 32'h1111_1111, "rd_during_wr");
    ld(F3_W, 32'h14, 32'h2222_2222, "wr_visible");
    st(F3_W, 32'h20, 32'h0);
    st(F3_B, 32'h21, 32'hAA);
    ld(F3_W, 32'h20, 32'h0000_AA00, "sb_21");
    st(F3_H, 32'h22, 32'hBEEF);
    ld(F3_W, 32'h20, 32'hBEEF_AA00, "sh_22");
    ld(3'b011, 32'h20, 32'hBEEF_AA00, "f3_011_ld");
    st(3'b111, 32'h24, 32'hCAFE_F00D);
    ld(F3_W, 32'h24, 32'hCAFE_F00D, "f3_111_st");
    st(F3_W, 32'h4000_0000, 32'h55);
    ld(F3_W, 32'h4000_0000, 32'h0, "unmapped_rd");
    st(F3_W, MB + 32'h20, 32'h1);
    ld(F3_W, MB + 32'h20, 32'h0, "mmio_unmapped_rd");
    chk(S_ERR, 32'h0, "unmapped_noerr");
    st(F3_W, MB + 32'h0C, 32'h5);
    st(F3_W, MB + 32'h10, 32'h1);
    ld(F3_W, MB + 32'h08, 32'h0, "cnt_0");
    ld(F3_W, MB + 32'h08, 32'h1, "cnt_1");
    chk(S_IRQ, 32'h0, "irq_cnt2");
    chk(S_IRQ, 32'h0, "irq_cnt3");
    ld(F3_W, MB + 32'h08, 32'h4, "cnt_4");
    chk(S_IRQ, 32'h0, "irq_cnt5");
    chk(S_IRQ, 32'h1, "irq_rise");
    ld(F3_W, MB + 32'h10, 32'h3, "ctrl_pend_en");
    st(F3_W, MB + 32'h08, 32'h5);
    st(F3_W, MB + 32'h10, 32'h2);
    chk(S_IRQ, 32'h1, "pend_set_wins");
    ld(F3_W, MB + 32'h10, 32'h2, "ctrl_en_off");
    ld(F3_W, MB + 32'h08, 32'h6, "cnt_wr_override");
    st(F3_W, MB + 32'h10, 32'h2);
    chk(S_IRQ, 32'h0, "pend_w1c");
    st(F3_W, MB + 32'h10, 32'h1);
    st(F3_W, MB + 32'h0C, 32'h6);
    chk(S_IRQ, 32'h0, "cmp_wr_nomatch");
    st(F3_W, MB + 32'h08, 32'hFFFF_FFFE);
    ld(F3_W, MB + 32'h08, 32'hFFFF_FFFE, "cnt_fe");
    ld(F3_W, MB + 32'h08, 32'hFFFF_FFFF, "cnt_ff");
    ld(F3_W, MB + 32'h08, 32'h0, "cnt_wrap");
    stc(F3_B, MB, 32'h11, S_ERR, 32'h0, "sb_mmio_pre");
    chk(S_ERR, 32'h1, "sb_mmio_err");
    chk(S_GPIO, 32'hA5, "sb_mmio_ignored");
    ld(F3_W, MB, 32'hA5, "gpio_rd_after_sb");
    ld(F3_W, MB + 32'h08, 32'h5, "cnt_5_rewrap");
    chk(S_IRQ, 32'h0, "irq_pre_rematch");
    chk(S_IRQ, 32'h1, "irq_rematch");
    reset = 1'b1;
    st(F3_W, 32'h10, 32'hDEAD_DEAD);
    reset = 1'b0;
    ld(F3_W, MB + 32'h08, 32'h0, "cnt_mid_rst");
    ld(F3_W, MB + 32'h10, 32'h0, "ctrl_mid_rst");
    chk(S_IRQ, 32'h0, "irq_mid_rst");
    chk(S_ERR, 32'h0, "err_mid_rst");
    chk(S_GPIO, 32'h0, "gpio_mid_rst");
    ld(F3_W, MB + 32'h0C, 32'hFFFF_FFFF, "cmp_mid_rst");
    ld(F3_W, 32'h10, 32'h8765_4321, "rst_drops_store");
    st(F3_W, 32'h30, 32'h1234_5678);
    stc(F3_H, 32'h31, 32'hFFFF, S_ERR, 32'h0, "sh_mis_pre");
    chk(S_ERR, 32'h1, "sh_mis_err");
    stc(F3_W, 32'h22, 32'hDEAD_BEEF, S_RD, 32'h0, "sw_mis_rd0");
    ld(F3_W, 32'h30, 32'h1234_5678, "sh_mis_noram");
    ld(F3_W, 32'h20, 32'hBEEF_AA00, "sw_mis_noram");
    ld(F3_H, 32'h31, 32'h0, "lh_mis_zero");
    ld(F3_W, 32'h32, 32'h0, "lw_mis_zero");
    chk(S_ERR, 32'h1, "err_sticky");
    checks++;
    if (q_sel.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sel.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side responder for the single-cycle RV32I core. It answers the core's data-bus accesses (address, write data, write enable, load/store size) with byte-addressable RAM and a small MMIO window: GPIO plus a compare timer. Reads are combinational so that load data returns in the same cycle. Writes commit on the clock edge.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of RAM words; byte range is `0 .. 4*DEPTH_WORDS-1`; must be a power of two.
- `MMIO_BASE`, default 32'h8000_0000: base of the MMIO window; the window decodes `dAddr[31:8] == MMIO_BASE[31:8]`.
- `GPIO_W`, default 8: GPIO width.

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `d_wr_en` in 1: store strobe for the current cycle.
- `d_funct3` in 3: access size from the instruction: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `dAddr` in 32: byte address (ALU result).
- `dWdata` in 32: store data, right-aligned (rs2).
- `dRdata` out 32: load data, extended per `d_funct3`; combinational.
- `gpio_in` in GPIO_W: external inputs.
- `gpio_out` out GPIO_W: registered outputs.
- `timer_irq` out 1: timer pending flag.
- `misalign_err` out 1: sticky error flag.

## Operation
- **RAM region** (`dAddr < 4*DEPTH_WORDS`):
  - Stores: B writes the byte lane `dAddr[1:0]`. H writes lanes {1:0} or {3:2}. W writes all lanes. Each lane uses the low bits of `dWdata`.
  - Loads: select the lane or lanes, then sign-extend (B, H) or zero-extend (BU, HU). W passes through.
  - RAM contents are not reset.
- **Misalignment**: H with `dAddr[0]=1`, or W with `dAddr[1:0]≠0`.
  - The store is suppressed and the load returns 0.
  - `misalign_err` sets on the next edge and stays set until reset.
- **MMIO region**: word access only.
  - A non-W access is treated as misaligned (same rule as above).
  - Register offsets:
    - 0x00 GPIO_OUT: RW.
    - 0x04 GPIO_IN: RO, zero-extended, sampled through one flop.
    - 0x08 TIMER_CNT: RW.
    - 0x0C TIMER_CMP: RW.
    - 0x10 TIMER_CTRL: bit0 EN (RW); bit1 PEND (read; write 1 to clear).
  - Unmapped offsets read 0 and ignore writes.
- **Unmapped addresses** (neither region): read 0, writes ignored, no error.
- **Undefined `d_funct3`** (011, 110, 111): treated as W for size. For a RAM load, W extension applies.
- **Timer**:
  - While EN=1, CNT increments by 1 each cycle and wraps from 0xFFFF_FFFF to 0.
  - PEND sets on any cycle where EN=1 and the current CNT == CMP.
  - `timer_irq` = PEND.

## Timing
- Read path is zero-latency combinational from `dAddr` and `d_funct3` to `dRdata`. A read in the same cycle as a write to the same address returns the old data.
- Writes (RAM, MMIO) take effect at the rising edge where `d_wr_en=1`; the new value is visible to a read in the following cycle.
- Reset values:
  - Outputs: `gpio_out`=0, `timer_irq`=0, `misalign_err`=0.
  - Registers: CNT=0, CMP=0xFFFF_FFFF, EN=0, GPIO_IN sample=0.
- Reset asserted mid-operation: all registers take their reset values on that edge and any concurrent store is dropped. RAM is untouched apart from that dropped store.
- Simultaneous events:
  - A software write to CNT overrides the increment on that edge.
  - A PEND set (match) and a W1C on the same edge: set wins.
  - A write to CMP equal to the current CNT does not match until the next cycle.
- Timer match uses pre-increment CNT. With CMP=5 and EN set, PEND rises on the edge after CNT reads 5.
- `gpio_in` has a 1-cycle sample latency, plus `gpio_out` register latency of 1 edge.

## Structure
- Package `rv32i_mem_pkg` holds:
  - size codes `F3_B/F3_H/F3_W/F3_BU/F3_HU`
  - MMIO offset constants `MMIO_GPIO_OUT … MMIO_TIMER_CTRL`
  - CTRL bit indices
- Sub-module `mmio_timer` holds CNT, CMP, EN, PEND, the match logic and the write-port decode inputs.
- The top module holds:
  - RAM as byte-lane write-enabled word array
  - load extract/extend logic
  - region decode
  - GPIO registers
  - error flag

## Test plan
- SW 0x8765_4321 to 0x10; then LB, LBU, LH, LHU and LW at 0x10 and 0x12 → 0x0000_0021, 0x21, 0x4321, 0x4321, 0x8765_4321; at 0x13: LB→0xFFFF_FF87, LBU→0x87; LH at 0x12→0xFFFF_8765.
- SB 0xAA to 0x21 over a word of 0 → LW 0x20 = 0x0000_AA00; SH 0xBEEF to 0x22 → LW 0x20 = 0xBEEF_AA00.
- SH to 0x31 and SW to 0x22 → no RAM change, `misalign_err`=1 from the next edge, load at 0x31 returns 0; clears only on reset.
- Write CMP=5, CTRL=1 → CNT counts, `timer_irq` rises on the edge after CNT=5; write CTRL=0b10 on the same edge as a re-match → PEND stays 1.
- Write CNT=0xFFFF_FFFE with EN=1 → reads 0xFFFF_FFFF then 0; assert reset mid-count → CNT=0, EN=0, `timer_irq`=0 next cycle.
- SW 0xA5 to MMIO_BASE+0x00 → `gpio_out`=0xA5 next edge; drive `gpio_in`=0x3C → LW MMIO_BASE+0x04 = 0x3C after one cycle; SB to MMIO_BASE+0x00 ignored and flags error.
